// File: rtl/ds1620_interface.sv
// DS1620 3-wire thermometer master: free-running convert / wait / read loop publishing TEMP.
// Optional `DS1620_CONFIG_EN: one-time 0x0C,0x02 configuration write after reset.
`timescale 1ns/1ps
module ds1620_interface #(
  parameter int HALF_BIT  = 2,
  parameter int CONV_WAIT = 16,
  parameter int RST_GAP   = 2
) (
  input  logic       CLK_IN,
  input  logic       CLR,
  input  logic       DQ_IN,
  output logic [8:0] TEMP,
  output logic       CLK_OUT,
  output logic       RST,
  output logic       TRI_EN,
  output logic       DQ_OUT
);

  typedef enum logic [3:0] {
    S_IDLE,
`ifdef DS1620_CONFIG_EN
    S_CFG,
    S_CFG_WAIT,
`endif
    S_CMD_CONV,
    S_GAP,
    S_WAIT_CONV,
    S_CMD_READ,
    S_READ_T,
    S_LATCH
  } state_t;

  localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);
  localparam logic [15:0] GAP_LAST  = 16'(RST_GAP - 1);
  localparam logic [15:0] WAIT_LAST = 16'(CONV_WAIT - 1);
`ifdef DS1620_CONFIG_EN
  localparam state_t FIRST_XFER = S_CFG;
`else
  localparam state_t FIRST_XFER = S_CMD_CONV;
`endif

  state_t      state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic [3:0]  bit_idx, bit_nx;
  logic        lead, lead_nx;
  logic        conv_done, conv_nx;
  logic [8:0]  shreg, shreg_nx;
  logic [8:0]  temp_nx;
  logic        clk_nx, rst_nx, tri_nx, dq_nx;
  logic        start_xfer, in_xfer;
  logic [15:0] cmd_word;
  logic [3:0]  last_bit;

  always_ff @(posedge CLK_IN or posedge CLR) begin
    if (CLR) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      lead      <= 1'b0;
      conv_done <= 1'b0;
      shreg     <= '0;
      TEMP      <= '0;
      CLK_OUT   <= 1'b1;
      RST       <= 1'b0;
      TRI_EN    <= 1'b0;
      DQ_OUT    <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      bit_idx   <= bit_nx;
      lead      <= lead_nx;
      conv_done <= conv_nx;
      shreg     <= shreg_nx;
      TEMP      <= temp_nx;
      CLK_OUT   <= clk_nx;
      RST       <= rst_nx;
      TRI_EN    <= tri_nx;
      DQ_OUT    <= dq_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt + 16'd1;
    bit_nx     = bit_idx;
    lead_nx    = lead;
    conv_nx    = conv_done;
    shreg_nx   = shreg;
    temp_nx    = TEMP;
    clk_nx     = CLK_OUT;
    rst_nx     = RST;
    tri_nx     = TRI_EN;
    dq_nx      = DQ_OUT;
    start_xfer = 1'b0;
    in_xfer    = 1'b0;
    cmd_word   = 16'h0000;
    last_bit   = 4'd0;

    case (state)
      S_IDLE: if (cnt == GAP_LAST) begin
        state_nx   = FIRST_XFER;
        start_xfer = 1'b1;
      end
`ifdef DS1620_CONFIG_EN
      S_CFG: begin
        in_xfer  = 1'b1;
        cmd_word = 16'h020C;
        last_bit = 4'd15;
      end
      S_CFG_WAIT: if (cnt == WAIT_LAST) begin
        state_nx   = S_CMD_CONV;
        start_xfer = 1'b1;
      end
`endif
      S_CMD_CONV: begin
        in_xfer  = 1'b1;
        cmd_word = 16'h00EE;
        last_bit = 4'd7;
      end
      S_GAP: if (cnt == GAP_LAST) begin
        conv_nx = 1'b0;
        cnt_nx  = '0;
        if (conv_done) begin
          state_nx = S_WAIT_CONV;
        end else begin
          state_nx   = S_CMD_CONV;
          start_xfer = 1'b1;
        end
      end
      S_WAIT_CONV: if (cnt == WAIT_LAST) begin
        state_nx   = S_CMD_READ;
        start_xfer = 1'b1;
      end
      S_CMD_READ: begin
        in_xfer  = 1'b1;
        cmd_word = 16'h00AA;
        last_bit = 4'd7;
      end
      S_READ_T: begin
        in_xfer  = 1'b1;
        last_bit = 4'd8;
      end
      S_LATCH: begin
        temp_nx  = shreg;
        cnt_nx   = '0;
        state_nx = S_GAP;
      end
      default: state_nx = S_IDLE;
    endcase

    if (start_xfer) begin
      cnt_nx  = '0;
      rst_nx  = 1'b1;
      clk_nx  = 1'b1;
      lead_nx = 1'b1;
      bit_nx  = '0;
      tri_nx  = 1'b0;
      dq_nx   = 1'b0;
    end

    // Each phase lasts HALF_BIT cycles; the end of a high phase either starts the next bit or closes the window.
    if (in_xfer && cnt == HALF_LAST) begin
      cnt_nx = '0;
      if (!CLK_OUT) begin
        clk_nx = 1'b1;
        if (state == S_READ_T) shreg_nx = {DQ_IN, shreg[8:1]};
      end else if (!lead && bit_idx == last_bit) begin
        if (state == S_CMD_READ) begin
          state_nx = S_READ_T;
          bit_nx   = '0;
          clk_nx   = 1'b0;
          tri_nx   = 1'b0;
          dq_nx    = 1'b0;
        end else begin
          rst_nx = 1'b0;
          tri_nx = 1'b0;
          dq_nx  = 1'b0;
          if (state == S_READ_T) begin
            state_nx = S_LATCH;
          end else if (state == S_CMD_CONV) begin
            state_nx = S_GAP;
            conv_nx  = 1'b1;
          end
`ifdef DS1620_CONFIG_EN
          else begin
            state_nx = S_CFG_WAIT;
          end
`endif
        end
      end else begin
        clk_nx  = 1'b0;
        lead_nx = 1'b0;
        bit_nx  = lead ? 4'd0 : bit_idx + 4'd1;
        if (state == S_READ_T) begin
          tri_nx = 1'b0;
          dq_nx  = 1'b0;
        end else begin
          tri_nx = 1'b1;
          dq_nx  = cmd_word[bit_nx];
        end
      end
    end
  end

endmodule

// File: tb/tb_ds1620_interface.sv
// Bench for ds1620_interface: behavioural DS1620 device model plus directed and random temperatures.
`timescale 1ns/1ps
module tb_ds1620_interface;

  localparam int HB    = 2;
  localparam int CW    = 16;
  localparam int RG    = 2;
  localparam int LIMIT = 4000;

  logic       CLK_IN = 1'b0;
  logic       CLR;
  logic       DQ_IN;
  logic [8:0] TEMP;
  logic       CLK_OUT;
  logic       RST;
  logic       TRI_EN;
  logic       DQ_OUT;

  int         checks = 0;
  int         errors = 0;
  logic       dead = 1'b0;
  logic [8:0] model_temp = 9'd0;

  ds1620_interface #(.HALF_BIT(HB), .CONV_WAIT(CW), .RST_GAP(RG)) dut (
    .CLK_IN (CLK_IN),
    .CLR    (CLR),
    .DQ_IN  (DQ_IN),
    .TEMP   (TEMP),
    .CLK_OUT(CLK_OUT),
    .RST    (RST),
    .TRI_EN (TRI_EN),
    .DQ_OUT (DQ_OUT)
  );

  always #5 CLK_IN = ~CLK_IN;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $display("[TB] FAIL timeout %s observed=expired expected=event within %0d cycles", tag, LIMIT);
    dead = 1'b1;
  endtask

  // Device model: waits for a RST window, records each bit at CLK_OUT rise and,
  // once the command byte reads 0xAA, serves the temperature LSB first after each fall.
  task automatic run_window(input logic [8:0] drive, input int abort_at,
                            output int nbits, output logic [31:0] dq_bits,
                            output logic [31:0] tri_bits, output logic stable,
                            output int gap, output logic gap_ok);
    int         guard;
    logic       prev_clk;
    logic [8:0] temp_start;
    nbits = 0; dq_bits = '0; tri_bits = '0; stable = 1'b1; gap = 0; gap_ok = 1'b1;
    while (!dead && RST !== 1'b1) begin
      @(negedge CLK_IN);
      if (RST === 1'b0 && TRI_EN !== 1'b0) gap_ok = 1'b0;
      gap++;
      if (gap > LIMIT) timeout("rst_rise");
    end
    if (dead) return;
    gap--;
    temp_start = TEMP;
    prev_clk   = CLK_OUT;
    guard      = 0;
    while (RST === 1'b1) begin
      @(negedge CLK_IN);
      if (TEMP !== temp_start) stable = 1'b0;
      if (!prev_clk && CLK_OUT && nbits < 32) begin
        dq_bits[nbits]  = DQ_OUT;
        tri_bits[nbits] = TRI_EN;
        nbits++;
      end
      if (prev_clk && !CLK_OUT) begin
        if (nbits == abort_at) begin
          CLR = 1'b1;
          return;
        end
        if (nbits >= 8 && nbits < 17 && dq_bits[7:0] == 8'hAA) DQ_IN = drive[nbits-8];
      end
      prev_clk = CLK_OUT;
      guard++;
      if (guard > LIMIT) begin
        timeout("rst_fall");
        return;
      end
    end
  endtask

  task automatic check_conv_window();
    int nb, gap; logic [31:0] dq, tr; logic st, gok;
    run_window(9'd0, -1, nb, dq, tr, st, gap, gok);
    check_output("conv_nbits", 32'(nb), 32'd8);
    check_output("conv_cmd", {24'd0, dq[7:0]}, 32'h0000_00EE);
    check_output("conv_tri", {24'd0, tr[7:0]}, 32'h0000_00FF);
    check_output("conv_temp_hold", {23'd0, TEMP}, {23'd0, model_temp});
    check_output("gap_tri_low", {31'd0, gok}, 32'd1);
  endtask

  task automatic apply_stimulus(input logic [8:0] drive);
    int nb, gap; logic [31:0] dq, tr; logic st, gok;
    check_conv_window();
    run_window(drive, -1, nb, dq, tr, st, gap, gok);
    check_output("read_nbits", 32'(nb), 32'd17);
    check_output("read_cmd", {24'd0, dq[7:0]}, 32'h0000_00AA);
    check_output("read_cmd_tri", {24'd0, tr[7:0]}, 32'h0000_00FF);
    check_output("read_tri_release", {23'd0, tr[16:8]}, 32'd0);
    check_output("read_dq_idle", {23'd0, dq[16:8]}, 32'd0);
    check_output("read_temp_atomic", {31'd0, st}, 32'd1);
    check_output("conv_wait_len", {31'd0, gap >= CW}, 32'd1);
    check_output("wait_tri_low", {31'd0, gok}, 32'd1);
    @(negedge CLK_IN);
    model_temp = drive;
    check_output("temp_latch", {23'd0, TEMP}, {23'd0, model_temp});
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_clk_out"}, {31'd0, CLK_OUT}, 32'd1);
    check_output({tag, "_rst"}, {31'd0, RST}, 32'd0);
    check_output({tag, "_tri_en"}, {31'd0, TRI_EN}, 32'd0);
    check_output({tag, "_dq_out"}, {31'd0, DQ_OUT}, 32'd0);
    check_output({tag, "_temp"}, {23'd0, TEMP}, 32'd0);
  endtask

  initial begin
    int nb, gap; logic [31:0] dq, tr; logic st, gok;
    CLR   = 1'b1;
    DQ_IN = 1'b0;
    #100;
    check_reset_outputs("reset");
    @(negedge CLK_IN);
    CLR = 1'b0;

`ifdef DS1620_CONFIG_EN
    run_window(9'd0, -1, nb, dq, tr, st, gap, gok);
    check_output("cfg_nbits", 32'(nb), 32'd16);
    check_output("cfg_cmd", {16'd0, dq[15:0]}, 32'h0000_020C);
    check_output("cfg_tri", {16'd0, tr[15:0]}, 32'h0000_FFFF);
`endif

    apply_stimulus(9'h032);
    apply_stimulus(9'h1CE);
    apply_stimulus(9'h000);
    for (int i = 0; i < 6; i++) apply_stimulus(9'($urandom));
    apply_stimulus(9'h0FF);

    // Abort in the middle of read bit 4; TEMP must clear and stay clear until a full loop completes.
    check_conv_window();
    run_window(9'h155, 12, nb, dq, tr, st, gap, gok);
    #1;
    check_reset_outputs("abort");
    model_temp = 9'd0;
    @(negedge CLK_IN);
    @(negedge CLK_IN);
    CLR = 1'b0;
    apply_stimulus(9'($urandom));
    apply_stimulus(9'h100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
